// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Owns the PC, fetches instruction words over a READ/BUSYWAIT handshake and
//   presents them to the decoder. After the decoder resolves JUMP/BRANCH and
//   the ALU resolves ZERO, it computes the next PC.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   JUMP, BRANCH, BNE   control-unit flow-change requests (BNE only with macro)
//   ZERO                ALU zero flag
//   OFFSET              signed offset in instructions (INSTRUCTION[23:16])
//   STALL               data-memory busywait, freezes the ISSUE state
//   IMEM_READ/ADDR      instruction memory request, address = PC
//   IMEM_READDATA       fetched word
//   IMEM_BUSYWAIT       memory not ready
//   INSTRUCTION         registered instruction word
//   INSTR_VALID         INSTRUCTION is live this cycle
//   PC                  address of the current instruction
//
// Configuration macro
//   BRANCH_NE_EN  defined: BNE & ~ZERO also selects the branch target.
//                 undefined: BNE is ignored.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  INSTR_WIDTH  = 32,
    parameter int                  OFFSET_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    JUMP,
    input  logic                    BRANCH,
    input  logic                    BNE,
    input  logic                    ZERO,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    input  logic                    STALL,
    output logic                    IMEM_READ,
    output logic [PC_WIDTH-1:0]     IMEM_ADDR,
    input  logic [INSTR_WIDTH-1:0]  IMEM_READDATA,
    input  logic                    IMEM_BUSYWAIT,
    output logic [INSTR_WIDTH-1:0]  INSTRUCTION,
    output logic                    INSTR_VALID,
    output logic [PC_WIDTH-1:0]     PC
);

    // S_IDLE exists only so that IMEM_READ stays low while reset is held;
    // the first edge after release moves to S_FETCH.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_latch;
    logic                    w_advance;
    logic                    w_take;
    logic [PC_WIDTH-1:0]     w_seq;
    logic [PC_WIDTH-1:0]     w_off_ext;
    logic [PC_WIDTH-1:0]     w_target;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic                    r_instr_valid;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: w_next_state = IMEM_BUSYWAIT ? S_WAIT : S_ISSUE;
            S_WAIT:  w_next_state = IMEM_BUSYWAIT ? S_WAIT : S_ISSUE;
            S_ISSUE: w_next_state = STALL ? S_ISSUE : S_FETCH;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        IMEM_READ = 1'b0;
        w_latch   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_FETCH, S_WAIT: begin
                IMEM_READ = 1'b1;
                w_latch   = ~IMEM_BUSYWAIT;
            end
            S_ISSUE: w_advance = ~STALL;
            default: ;
        endcase
    end

    // ---------------- next-PC datapath ----------------
    // Offset counts instructions, so it is scaled by 4 bytes. All arithmetic
    // is modulo 2^PC_WIDTH and wraps silently.
    assign w_seq     = r_pc + PC_WIDTH'(4);
    assign w_off_ext = {{(PC_WIDTH-OFFSET_WIDTH){OFFSET[OFFSET_WIDTH-1]}}, OFFSET};
    assign w_target  = w_seq + (w_off_ext << 2);

`ifdef BRANCH_NE_EN
    assign w_take = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
`else
    // BNE is deliberately left unloaded in the BEQ-only build.
    logic w_unused_bne;
    assign w_unused_bne = BNE;
    assign w_take = JUMP | (BRANCH & ZERO);
`endif

    // ---------------- PC / instruction registers ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_latch) begin
                r_instr       <= IMEM_READDATA;
                r_instr_valid <= 1'b1;
            end
            if (w_advance) begin
                r_pc          <= w_take ? w_target : w_seq;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign IMEM_ADDR   = r_pc;
    assign PC          = r_pc;
    assign INSTRUCTION = r_instr;
    assign INSTR_VALID = r_instr_valid;

endmodule
